captura_matriz: RTL
===================

# captura_matriz

Receiver for the multiplexed 5x7 LED-matrix scan produced by the display path. It watches the active-low one-hot column strobe and the five row lines and rebuilds the complete 35-pixel frame the scanner is painting. It checks that columns arrive in scan order and publishes each completed frame with a one-cycle valid pulse. It sits beside the display top as an on-chip monitor/checker, or on a second board that decodes a captured scan bus.

## Interface
- N_COL, 7, number of columns; strobe width.
- N_LIN, 5, number of rows.
- SETTLE, 2, consecutive cycles (>=1) a valid column must be held before its rows are sampled.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- coluna_in  in  N_COL  column strobe, active-low one-hot; bit k low = column k lit.
- linha_in  in  N_LIN  row data; 1 = pixel on.
- quadro  out  N_COL*N_LIN  last complete frame; bit c*N_LIN+r = column c, row r.
- quadro_valido  out  1  one-cycle pulse when quadro is updated.
- erro_seq  out  1  one-cycle pulse on a scan violation.
- sincronizado  out  1  high while in ST_CAPT.
- quadros_ok  out  8  count of completed frames; wraps 255->0.

## Operation
- Decode the strobe into one of three classes:
  - valid: exactly one bit low; index = position of the low bit.
  - blank: all bits high.
  - multiple: two or more bits low.
- Stability counter:
  - Restarts whenever the strobe pattern differs from the previous cycle's pattern.
  - Saturates at SETTLE.
  - A valid column is sampled exactly once per dwell: on the cycle the counter reaches SETTLE. Afterwards it is ignored until the pattern changes.
- Blank: never sampled, never an error. It is the inter-column gap.
- Multiple, stable for SETTLE cycles: pulse erro_seq, discard the shadow buffer, go to ST_SYNC.
- FSM:
  - ST_SYNC: ignore every column except 0. A sample of column 0 stores its rows in shadow[0], sets esperado=1, goes to ST_CAPT.
  - ST_CAPT, sampled column == esperado, esperado < N_COL-1: store rows in shadow[esperado], increment esperado.
  - ST_CAPT, sampled column == esperado == N_COL-1: on the same edge, load quadro with {linha_in, shadow[N_COL-2:0]}, pulse quadro_valido, increment quadros_ok, set esperado=0, stay in ST_CAPT.
  - ST_CAPT, sampled column != esperado: pulse erro_seq, go to ST_SYNC. If that column is 0, it is not reused to resync; a later dwell of column 0 is needed.
- A repeated dwell of the same column, with a blank gap between, is out of order and raises erro_seq.
- quadro holds its value through errors and resync. Only a complete in-order frame replaces it.
- Reset, including mid-frame: quadro=0, quadro_valido=0, erro_seq=0, sincronizado=0, quadros_ok=0, shadow=0, esperado=0, counter=0, state ST_SYNC.

## Timing
- Macro disabled: column k applied and held from cycle t gives its sample on the edge ending cycle t+SETTLE-1.
- Column N_COL-1 held from cycle t: quadro and quadro_valido are visible in cycle t+SETTLE.
- quadro_valido and erro_seq never assert in the same cycle. A sample is either in order or it is not.
- A dwell shorter than SETTLE cycles is never sampled. If that skips a column, the next sample raises erro_seq.
- All outputs are registered.

## Configuration
- CAPTURA_SYNC_EN defined: coluna_in and linha_in each pass through a two-flop synchronizer, reset to all-ones and all-zeros respectively. All latencies grow by 2 cycles. Use this when inputs are asynchronous to clk.
- CAPTURA_SYNC_EN undefined: inputs feed the decoder directly and must be synchronous to clk.

## Structure
- Package captura_pkg holds:
  - Default N_COL/N_LIN constants.
  - FSM state enum (ST_SYNC, ST_CAPT).
  - Strobe class enum (VALIDA, VAZIA, MULTIPLA).
- Sub-module decodificador_coluna: purely combinational; strobe in, class and index out. This keeps the one-hot check separately testable.

## Test plan
- Reset, then 3 ordered scans of columns 0..6, each dwell 4 cycles with 1 blank cycle between, rows = c+1 -> three quadro_valido pulses; quadro column c = c+1; quadros_ok = 3; erro_seq never high.
- Scan order 0,1,2,4 -> erro_seq pulse on the column-4 sample; sincronizado falls; quadro unchanged. The next full 0..6 scan produces a valid frame.
- Column 3 held for only 1 cycle (SETTLE=2) -> no sample; column 4 then raises erro_seq.
- Strobe 0b1110110 held 3 cycles mid-frame -> erro_seq pulse, return to ST_SYNC.
- rst_n pulsed low while column 5 is being sampled -> all outputs 0 asynchronously; the first frame after release requires a fresh column 0.
- 256 clean frames -> quadros_ok wraps to 0; quadro_valido pulses exactly 256 times.

Source files
------------

// File: rtl/captura_pkg.sv
// +----------------------------------------------------------------------+
// | captura_pkg: shared constants and enums for the LED-matrix capture.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package captura_pkg;

  localparam int N_COL_DEF = 7;
  localparam int N_LIN_DEF = 5;

  typedef enum logic {
    ST_SYNC = 1'b0,
    ST_CAPT = 1'b1
  } estado_t;

  typedef enum logic [1:0] {
    VALIDA   = 2'd0,
    VAZIA    = 2'd1,
    MULTIPLA = 2'd2
  } classe_t;

endpackage

`default_nettype wire

// File: rtl/captura_matriz_if.sv
// +----------------------------------------------------------------------+
// | captura_matriz_if: scan bus in, rebuilt frame and status out.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

interface captura_matriz_if
  import captura_pkg::*;
#(
  parameter int N_COL = N_COL_DEF,
  parameter int N_LIN = N_LIN_DEF
);

  logic [N_COL-1:0]       coluna_in;
  logic [N_LIN-1:0]       linha_in;
  logic [N_COL*N_LIN-1:0] quadro;
  logic                   quadro_valido;
  logic                   erro_seq;
  logic                   sincronizado;
  logic [7:0]             quadros_ok;

  modport master (
    output coluna_in, linha_in,
    input  quadro, quadro_valido, erro_seq, sincronizado, quadros_ok
  );

  modport slave (
    input  coluna_in, linha_in,
    output quadro, quadro_valido, erro_seq, sincronizado, quadros_ok
  );

endinterface

`default_nettype wire

// File: rtl/captura_matriz_decodificador_coluna.sv
// +----------------------------------------------------------------------+
// | decodificador_coluna: classifies the active-low column strobe and    |
// | returns the index of the lowest low bit. Purely combinational.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module decodificador_coluna
  import captura_pkg::*;
#(
  parameter int N_COL = N_COL_DEF,
  parameter int IW    = (N_COL > 1) ? $clog2(N_COL) : 1
) (
  input  logic [N_COL-1:0] coluna,
  output classe_t          classe,
  output logic [IW-1:0]    indice
);

  localparam int CW = $clog2(N_COL + 1);

  logic [CW-1:0] w_n_baixos;

  always_comb begin
    w_n_baixos = '0;
    indice     = '0;
    for (int k = N_COL - 1; k >= 0; k--) begin
      if (!coluna[k]) begin
        w_n_baixos = w_n_baixos + CW'(1);
        indice     = IW'(k);
      end
    end
    if (w_n_baixos == '0)
      classe = VAZIA;
    else if (w_n_baixos == CW'(1))
      classe = VALIDA;
    else
      classe = MULTIPLA;
  end

endmodule

`default_nettype wire

// File: rtl/captura_matriz.sv
// +----------------------------------------------------------------------+
// | captura_matriz: rebuilds 5x7 frames from the multiplexed scan bus,   |
// | checks column order. Option: CAPTURA_SYNC_EN adds 2-flop input sync. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module captura_matriz
  import captura_pkg::*;
#(
  parameter int N_COL  = N_COL_DEF,
  parameter int N_LIN  = N_LIN_DEF,
  parameter int SETTLE = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  captura_matriz_if.slave    bus
);

  localparam int            IW       = (N_COL > 1) ? $clog2(N_COL) : 1;
  localparam int            CW       = $clog2(SETTLE + 1);
  localparam logic [CW-1:0] SETTLE_C = CW'(SETTLE);
  localparam logic [IW-1:0] ULTIMA   = IW'(N_COL - 1);

  logic [N_COL-1:0] w_col;
  logic [N_LIN-1:0] w_lin;

`ifdef CAPTURA_SYNC_EN
  logic [N_COL-1:0] r_col_m, r_col_s;
  logic [N_LIN-1:0] r_lin_m, r_lin_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col_m <= '1;
      r_col_s <= '1;
      r_lin_m <= '0;
      r_lin_s <= '0;
    end else begin
      r_col_m <= bus.coluna_in;
      r_col_s <= r_col_m;
      r_lin_m <= bus.linha_in;
      r_lin_s <= r_lin_m;
    end
  end

  assign w_col = r_col_s;
  assign w_lin = r_lin_s;
`else
  assign w_col = bus.coluna_in;
  assign w_lin = bus.linha_in;
`endif

  classe_t       w_classe;
  logic [IW-1:0] w_indice;

  decodificador_coluna #(
    .N_COL (N_COL),
    .IW    (IW)
  ) u_decod (
    .coluna (w_col),
    .classe (w_classe),
    .indice (w_indice)
  );

  // Dwell counter: cycles the current pattern has been seen, including this one.
  logic [N_COL-1:0] r_col_ant;
  logic [CW-1:0]    r_cnt, w_cnt_n;
  logic             w_amostra;

  always_comb begin
    w_cnt_n   = CW'(1);
    w_amostra = (SETTLE_C == CW'(1));
    if (w_col == r_col_ant) begin
      w_cnt_n   = (r_cnt < SETTLE_C) ? r_cnt + CW'(1) : r_cnt;
      w_amostra = (r_cnt < SETTLE_C) && (r_cnt + CW'(1) == SETTLE_C);
    end
  end

  estado_t                r_estado, w_estado_n;
  logic [IW-1:0]          r_esperado, w_esperado_n;
  logic [N_LIN-1:0]       r_shadow   [N_COL-1];
  logic [N_LIN-1:0]       w_shadow_n [N_COL-1];
  logic [N_COL*N_LIN-1:0] r_quadro, w_quadro_n;
  logic                   r_valido, w_valido_n;
  logic                   r_erro, w_erro_n;
  logic                   r_sinc;
  logic [7:0]             r_ok, w_ok_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_estado <= ST_SYNC;
    else
      r_estado <= w_estado_n;
  end

  always_comb begin
    w_estado_n   = r_estado;
    w_esperado_n = r_esperado;
    w_shadow_n   = r_shadow;
    w_quadro_n   = r_quadro;
    w_valido_n   = 1'b0;
    w_erro_n     = 1'b0;
    w_ok_n       = r_ok;
    if (w_amostra) begin
      case (w_classe)
        MULTIPLA: begin
          w_erro_n     = 1'b1;
          w_estado_n   = ST_SYNC;
          w_esperado_n = '0;
          for (int c = 0; c < N_COL - 1; c++)
            w_shadow_n[c] = '0;
        end
        VALIDA: begin
          if (r_estado == ST_SYNC) begin
            if (w_indice == '0) begin
              w_shadow_n[0] = w_lin;
              w_esperado_n  = IW'(1);
              w_estado_n    = ST_CAPT;
            end
          end else if (w_indice != r_esperado) begin
            // An out-of-order column 0 is not reused; resync waits for a new dwell.
            w_erro_n     = 1'b1;
            w_estado_n   = ST_SYNC;
            w_esperado_n = '0;
          end else if (r_esperado == ULTIMA) begin
            for (int c = 0; c < N_COL - 1; c++)
              w_quadro_n[c*N_LIN +: N_LIN] = r_shadow[c];
            w_quadro_n[(N_COL-1)*N_LIN +: N_LIN] = w_lin;
            w_valido_n   = 1'b1;
            w_ok_n       = r_ok + 8'd1;
            w_esperado_n = '0;
          end else begin
            w_shadow_n[r_esperado] = w_lin;
            w_esperado_n           = r_esperado + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col_ant  <= '1;
      r_cnt      <= '0;
      r_esperado <= '0;
      for (int c = 0; c < N_COL - 1; c++)
        r_shadow[c] <= '0;
      r_quadro   <= '0;
      r_valido   <= 1'b0;
      r_erro     <= 1'b0;
      r_sinc     <= 1'b0;
      r_ok       <= '0;
    end else begin
      r_col_ant  <= w_col;
      r_cnt      <= w_cnt_n;
      r_esperado <= w_esperado_n;
      r_shadow   <= w_shadow_n;
      r_quadro   <= w_quadro_n;
      r_valido   <= w_valido_n;
      r_erro     <= w_erro_n;
      r_sinc     <= (w_estado_n == ST_CAPT);
      r_ok       <= w_ok_n;
    end
  end

  assign bus.quadro        = r_quadro;
  assign bus.quadro_valido = r_valido;
  assign bus.erro_seq      = r_erro;
  assign bus.sincronizado  = r_sinc;
  assign bus.quadros_ok    = r_ok;

endmodule

`default_nettype wire
